// File: rtl/load_data_extender.sv
// Load-path sign/zero extension: picks the byte/halfword lane of a little-endian
// memory word by byte offset and extends it to 32 bits, optionally registered.
module load_data_extender #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in8,
  input  logic [15:0] in16,
  input  logic        EXTOp,
  output logic [31:0] ext8_out,
  output logic [31:0] ext16_out,
  input  logic        valid_in,
  input  logic [1:0]  MemOp,
  input  logic [31:0] word_in,
  input  logic [1:0]  byte_off,
  output logic        valid_out,
  output logic [31:0] out32,
  output logic        misalign
);

  typedef struct packed {
    logic [31:0] data;
    logic        misalign;
  } ld_rsp_t;

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sext);
    return sext ? {{24{v[7]}}, v} : {24'b0, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sext);
    return sext ? {{16{v[15]}}, v} : {16'b0, v};
  endfunction

  assign ext8_out  = ext8(in8, EXTOp);
  assign ext16_out = ext16(in16, EXTOp);

  logic [7:0]  lane8;
  logic [15:0] lane16;
  ld_rsp_t     rsp;

  always_comb begin
    lane8 = word_in[7:0];
    case (byte_off)
      2'd1:    lane8 = word_in[15:8];
      2'd2:    lane8 = word_in[23:16];
      2'd3:    lane8 = word_in[31:24];
      default: lane8 = word_in[7:0];
    endcase
    lane16 = byte_off[1] ? word_in[31:16] : word_in[15:0];
  end

  // Word loads (and the reserved 2'b11 encoding) bypass offset and EXTOp
  // entirely so X on those inputs cannot leak into the result.
  always_comb begin
    rsp.data     = word_in;
    rsp.misalign = 1'b0;
    case (MemOp)
      2'b00: rsp.data = ext8(lane8, EXTOp);
      2'b01: begin
        if (byte_off[0]) begin
          rsp.data     = 32'h0;
          rsp.misalign = 1'b1;
        end else begin
          rsp.data = ext16(lane16, EXTOp);
        end
      end
      default: rsp.data = word_in;
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [31:0] out32_q, out32_d;
      logic        misalign_q, misalign_d;
      logic        valid_q, valid_d;

      always_comb begin
        out32_d    = out32_q;
        misalign_d = misalign_q;
        valid_d    = valid_in;
        if (valid_in) begin
          out32_d    = rsp.data;
          misalign_d = rsp.misalign;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          out32_q    <= 32'h0;
          misalign_q <= 1'b0;
          valid_q    <= 1'b0;
        end else begin
          out32_q    <= out32_d;
          misalign_q <= misalign_d;
          valid_q    <= valid_d;
        end
      end

      assign out32     = out32_q;
      assign misalign  = misalign_q;
      assign valid_out = valid_q;
    end else begin : g_comb
      assign out32     = rsp.data;
      assign misalign  = rsp.misalign;
      assign valid_out = valid_in;
    end
  endgenerate

endmodule

// File: tb/tb_load_data_extender.sv
// Self-checking bench for load_data_extender (REG_OUT=1): directed spec vectors
// plus randomized loads checked against an arithmetic reference model.
module tb_load_data_extender;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in8;
  logic [15:0] in16;
  logic        EXTOp;
  logic [31:0] ext8_out, ext16_out;
  logic        valid_in;
  logic [1:0]  MemOp;
  logic [31:0] word_in;
  logic [1:0]  byte_off;
  logic        valid_out;
  logic [31:0] out32;
  logic        misalign;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_data_extender #(.REG_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .in8(in8), .in16(in16), .EXTOp(EXTOp),
    .ext8_out(ext8_out), .ext16_out(ext16_out), .valid_in(valid_in),
    .MemOp(MemOp), .word_in(word_in), .byte_off(byte_off),
    .valid_out(valid_out), .out32(out32), .misalign(misalign)
  );

  // Reference: extract lane by shifting/modulo, sign-extend by subtracting 2^n.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] w,
                                        input logic [1:0] off, input logic sext);
    longint v;
    logic [31:0] r;
    if (op == 2'd0) begin
      v = (longint'(w) >> (8 * off)) % 256;
      if (sext && v >= 128) v = v - 256;
    end else if (op == 2'd1) begin
      if (off % 2 == 1) return {1'b1, 32'h0};
      v = (longint'(w) >> (8 * off)) % 65536;
      if (sext && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    r = v[31:0];
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] model_ext(input longint v, input int bits, input logic sext);
    longint r;
    logic [31:0] o;
    r = v;
    if (sext && v >= (longint'(1) << (bits - 1))) r = v - (longint'(1) << bits);
    o = r[31:0];
    return o;
  endfunction

  task automatic drive(input logic vld, input logic [1:0] op, input logic [31:0] w,
                       input logic [1:0] off, input logic sext);
    valid_in = vld; MemOp = op; word_in = w; byte_off = off; EXTOp = sext;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 2'd2, 32'hFFFF_FFFF, 2'd0, 1'b0);
    tick; tick;
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", valid_out); end
    n_chk++; if (out32 !== 32'h0) begin n_fail++; $display("FAIL reset_out32 got=%h want=00000000", out32); end
    n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b want=0", misalign); end
    rst = 1'b0;
  endtask

  task automatic test_direct;
    logic [31:0] e;
    in8 = 8'h80; EXTOp = 1'b1; #1;
    n_chk++; if (ext8_out !== 32'hFFFFFF80) begin n_fail++; $display("FAIL t1_ext8_s got=%h want=FFFFFF80", ext8_out); end
    EXTOp = 1'b0; #1;
    n_chk++; if (ext8_out !== 32'h00000080) begin n_fail++; $display("FAIL t1_ext8_z got=%h want=00000080", ext8_out); end
    in16 = 16'h7FFF; EXTOp = 1'b1; #1;
    n_chk++; if (ext16_out !== 32'h00007FFF) begin n_fail++; $display("FAIL t1_ext16 got=%h want=00007FFF", ext16_out); end
    for (int i = 0; i < 40; i++) begin
      in8 = 8'($urandom); in16 = 16'($urandom); EXTOp = 1'($urandom); #1;
      e = model_ext(longint'(in8), 8, EXTOp);
      n_chk++; if (ext8_out !== e) begin n_fail++; $display("FAIL rnd_ext8 in=%h s=%b got=%h want=%h", in8, EXTOp, ext8_out, e); end
      e = model_ext(longint'(in16), 16, EXTOp);
      n_chk++; if (ext16_out !== e) begin n_fail++; $display("FAIL rnd_ext16 in=%h s=%b got=%h want=%h", in16, EXTOp, ext16_out, e); end
    end
  endtask

  task automatic test_byte;
    logic [31:0] want [5] = '{32'h0000005D, 32'h0000006C, 32'h0000007B, 32'hFFFFFF8A, 32'h0000008A};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 32'h8A7B6C5D, (i == 4) ? 2'd3 : 2'(i), (i == 4) ? 1'b0 : 1'b1);
      tick;
      n_chk++; if (out32 !== want[i] || valid_out !== 1'b1) begin
        n_fail++; $display("FAIL t2_byte_%0d got=%h/v%b want=%h/v1", i, out32, valid_out, want[i]);
      end
    end
  endtask

  task automatic test_half;
    logic [1:0]  offs [3] = '{2'd0, 2'd2, 2'd2};
    logic        sx   [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] want [3] = '{32'hFFFFF234, 32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 32'h8001F234, offs[i], sx[i]);
      tick;
      n_chk++; if (out32 !== want[i] || misalign !== 1'b0) begin
        n_fail++; $display("FAIL t3_half_%0d got=%h/m%b want=%h/m0", i, out32, misalign, want[i]);
      end
    end
  endtask

  task automatic test_misalign;
    drive(1'b1, 2'd1, 32'hDEADBEEF, 2'd1, 1'b1);
    tick;
    n_chk++; if (out32 !== 32'h0 || misalign !== 1'b1 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL t4_misalign got=%h/m%b/v%b want=00000000/m1/v1", out32, misalign, valid_out);
    end
    drive(1'b1, 2'd2, 32'hCAFEF00D, 2'd3, 1'b1);
    tick;
    n_chk++; if (out32 !== 32'hCAFEF00D || misalign !== 1'b0) begin
      n_fail++; $display("FAIL t4_word got=%h/m%b want=CAFEF00D/m0", out32, misalign);
    end
    // reserved MemOp=3 behaves as word, offset/EXTOp ignored
    drive(1'b1, 2'd3, 32'h80000081, 2'd1, 1'b1);
    tick;
    n_chk++; if (out32 !== 32'h80000081 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL t4_op3 got=%h/m%b want=80000081/m0", out32, misalign);
    end
    drive(1'b1, 2'd2, 32'h1234ABCD, 2'bxx, 1'bx);
    tick;
    n_chk++; if (out32 !== 32'h1234ABCD || misalign !== 1'b0) begin
      n_fail++; $display("FAIL t4_word_x got=%h/m%b want=1234ABCD/m0", out32, misalign);
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp [4];
    logic [1:0]  op;
    logic [31:0] w;
    logic [1:0]  off;
    logic        s;
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom_range(0, 2)); w = $urandom; off = 2'($urandom); s = 1'($urandom);
      exp[i] = model(op, w, off, s);
      drive(1'b1, op, w, off, s);
      tick;
      n_chk++; if (valid_out !== 1'b1 || {misalign, out32} !== exp[i]) begin
        n_fail++; $display("FAIL t5_b2b_%0d got=%b/%h/v%b want=%b/%h/v1", i, misalign, out32, valid_out, exp[i][32], exp[i][31:0]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 2'($urandom), $urandom, 2'($urandom), 1'($urandom));
      tick;
      n_chk++; if (valid_out !== 1'b0 || {misalign, out32} !== exp[3]) begin
        n_fail++; $display("FAIL t5_hold_%0d got=%b/%h/v%b want=%b/%h/v0", k, misalign, out32, valid_out, exp[3][32], exp[3][31:0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [32:0] e;
    drive(1'b1, 2'd1, 32'h0000FFFF, 2'd1, 1'b1);
    tick;
    rst = 1'b1;
    drive(1'b1, 2'd2, 32'hA5A5A5A5, 2'd0, 1'b0);
    tick;
    n_chk++; if (valid_out !== 1'b0 || out32 !== 32'h0 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL t6_rst got=%h/m%b/v%b want=00000000/m0/v0", out32, misalign, valid_out);
    end
    rst = 1'b0;
    drive(1'b1, 2'd0, 32'h00F00000, 2'd2, 1'b1);
    e = model(2'd0, 32'h00F00000, 2'd2, 1'b1);
    tick;
    n_chk++; if (valid_out !== 1'b1 || {misalign, out32} !== e) begin
      n_fail++; $display("FAIL t6_after got=%h/v%b want=%h/v1", out32, valid_out, e[31:0]);
    end
  endtask

  task automatic test_random;
    logic [32:0] last;
    logic [32:0] e;
    logic        v;
    logic [1:0]  op;
    logic [31:0] w;
    logic [1:0]  off;
    logic        s;
    drive(1'b0, 2'd0, 32'h0, 2'd0, 1'b0);
    last = {misalign, out32};
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      op = 2'($urandom); w = $urandom; off = 2'($urandom); s = 1'($urandom);
      e = model(op, w, off, s);
      drive(v, op, w, off, s);
      tick;
      if (v) last = e;
      n_chk++; if (valid_out !== v || {misalign, out32} !== last) begin
        n_fail++; $display("FAIL rnd_%0d op=%0d w=%h off=%0d s=%b got=%b/%h/v%b want=%b/%h/v%b",
                           i, op, w, off, s, misalign, out32, valid_out, last[32], last[31:0], v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in8 = '0; in16 = '0;
    drive(1'b0, 2'd0, 32'h0, 2'd0, 1'b0);
    test_reset;
    test_direct;
    test_byte;
    test_half;
    test_misalign;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
